// File: rtl/sl_preceptron_weight_loader.sv
// Weight loader: streams VECTOR_LENGTH weights into a RAM starting at a base
// address, then reads them back and compares write-side and read-side checksums.
module sl_preceptron_weight_loader #(
    parameter int unsigned WEIGHTS_WIDTH  = 8,
    parameter int unsigned MEM_ADDR_WIDTH = 16,
    parameter int unsigned VECTOR_LENGTH  = 64,
    parameter int unsigned CHECKSUM_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic                      s_valid,
    input  logic [WEIGHTS_WIDTH-1:0]  s_data,
    output logic                      s_ready,
    output logic                      mem_wen,
    output logic                      mem_ren,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [WEIGHTS_WIDTH-1:0]  mem_wdata,
    input  logic [WEIGHTS_WIDTH-1:0]  mem_rdata,
    output logic                      busy,
    output logic                      done,
    output logic [CHECKSUM_WIDTH-1:0] status_checksum,
    output logic                      status_error
);

    // Index must also hold VECTOR_LENGTH: VERIFY uses it to mark "all reads issued".
    localparam int unsigned   IdxW    = $clog2(VECTOR_LENGTH + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(VECTOR_LENGTH - 1);
    localparam logic [IdxW-1:0] NumIdx  = IdxW'(VECTOR_LENGTH);

    typedef enum logic [2:0] {StIdle, StLoad, StVerify, StDrain, StDone} state_e;

    state_e                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [IdxW-1:0]           idx_q, idx_d;
    logic [CHECKSUM_WIDTH-1:0] wr_sum_q, wr_sum_d;
    logic [CHECKSUM_WIDTH-1:0] rd_sum_q, rd_sum_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      mem_wen_q, mem_wen_d;
    logic                      mem_ren_q, mem_ren_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WEIGHTS_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [CHECKSUM_WIDTH-1:0] status_checksum_q, status_checksum_d;
    logic                      status_error_q, status_error_d;
    logic [MEM_ADDR_WIDTH-1:0] cur_addr;

    assign cur_addr = base_q + MEM_ADDR_WIDTH'(idx_q);

    // Next-state and registered-output computation.
    always_comb begin
        state_d           = state_q;
        base_d            = base_q;
        idx_d             = idx_q;
        wr_sum_d          = wr_sum_q;
        mem_wen_d         = 1'b0;
        mem_ren_d         = 1'b0;
        mem_addr_d        = mem_addr_q;
        mem_wdata_d       = mem_wdata_q;
        status_checksum_d = status_checksum_q;
        status_error_d    = status_error_q;
        // Read data lands the cycle after a read strobe.
        rd_valid_d        = mem_ren_q;
        rd_sum_d          = rd_valid_q ? rd_sum_q + CHECKSUM_WIDTH'(mem_rdata) : rd_sum_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLoad;
                    base_d     = base_addr;
                    idx_d      = '0;
                    wr_sum_d   = '0;
                    rd_sum_d   = '0;
                    rd_valid_d = 1'b0;
                end
            end
            StLoad: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (s_valid) begin
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = cur_addr;
                    mem_wdata_d = s_data;
                    wr_sum_d    = wr_sum_q + CHECKSUM_WIDTH'(s_data);
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StVerify;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StVerify: begin
                // First cycle here still shows the last write, so reads start one later.
                if (abort) begin
                    state_d    = StIdle;
                    rd_valid_d = 1'b0;
                end else if (idx_q != NumIdx) begin
                    mem_ren_d  = 1'b1;
                    mem_addr_d = cur_addr;
                    idx_d      = idx_q + 1'b1;
                end else begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d    = StIdle;
                    rd_valid_d = 1'b0;
                end else begin
                    // rd_sum_d already includes the final read beat.
                    state_d           = StDone;
                    status_checksum_d = wr_sum_q;
                    status_error_d    = (wr_sum_q != rd_sum_d);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            base_q            <= '0;
            idx_q             <= '0;
            wr_sum_q          <= '0;
            rd_sum_q          <= '0;
            rd_valid_q        <= 1'b0;
            mem_wen_q         <= 1'b0;
            mem_ren_q         <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            status_checksum_q <= '0;
            status_error_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            base_q            <= base_d;
            idx_q             <= idx_d;
            wr_sum_q          <= wr_sum_d;
            rd_sum_q          <= rd_sum_d;
            rd_valid_q        <= rd_valid_d;
            mem_wen_q         <= mem_wen_d;
            mem_ren_q         <= mem_ren_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            status_checksum_q <= status_checksum_d;
            status_error_q    <= status_error_d;
        end
    end

    assign s_ready         = (state_q == StLoad);
    assign busy            = (state_q != StIdle);
    assign done            = (state_q == StDone);
    assign mem_wen         = mem_wen_q;
    assign mem_ren         = mem_ren_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign status_checksum = status_checksum_q;
    assign status_error    = status_error_q;

endmodule

// File: tb/tb_sl_preceptron_weight_loader.sv
// Bench for the weight loader: RAM model, write/read scoreboards, directed loads.
module tb_sl_preceptron_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] base_addr;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        mem_wen;
    logic        mem_ren;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [15:0] status_checksum;
    logic        status_error;

    logic [7:0]  ram [65536];
    logic        corrupt;

    int          checks;
    int          errors;
    int          done_cnt;
    logic [23:0] wr_q [$];
    logic [15:0] rd_q [$];

    sl_preceptron_weight_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .base_addr       (base_addr),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .mem_wen         (mem_wen),
        .mem_ren         (mem_ren),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .done            (done),
        .status_checksum (status_checksum),
        .status_error    (status_error)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model; optionally corrupts address 0x0105 on write.
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= (corrupt && mem_addr == 16'h0105) ? 8'hFF : mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] patv(input int p, input int i);
        if (p == 0) return 8'(i);
        if (p == 1) return 8'h01;
        return 8'(i * 7 + 3);
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic [15:0] addr);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s_ready_wait", 32'(s_ready), 32'd1);
        wr_q.push_back({addr, d});
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] base);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic run_load(input logic [15:0] base, input int pat, input int gap,
                            output logic [15:0] sum);
        logic [7:0] d;
        sum = '0;
        do_start(base);
        for (int i = 0; i < 64; i++) rd_q.push_back(base + 16'(i));
        for (int i = 0; i < 64; i++) begin
            d   = patv(pat, i);
            sum = sum + 16'(d);
            send_beat(d, base + 16'(i));
            if (gap != 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input string tag, input logic [15:0] exp_cs, input logic exp_err);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk({tag, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, "_checksum"}, 32'(status_checksum), 32'(exp_cs));
        chk({tag, "_error"}, 32'(status_error), 32'(exp_err));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_writes_left"}, 32'(wr_q.size()), 32'd0);
        chk({tag, "_reads_left"}, 32'(rd_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
        chk({tag, "_mem_ren"}, 32'(mem_ren), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_status_checksum"}, 32'(status_checksum), 32'd0);
        chk({tag, "_status_error"}, 32'(status_error), 32'd0);
    endtask

    initial begin
        logic [15:0] sum;
        logic [15:0] prev_cs;
        logic        prev_err;
        logic [23:0] exp_w;
        logic [15:0] exp_r;
        int          d0;

        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        corrupt   = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        s_valid   = 1'b0;
        s_data    = '0;

        // Bus monitor: pops the scoreboards whenever the DUT strobes the RAM.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (mem_wen || mem_ren) begin
                        checks++;
                        assert (!(mem_wen && mem_ren)) else begin
                            errors++;
                            $error("FAIL strobe_overlap: wen=%0b ren=%0b, required not both",
                                   mem_wen, mem_ren);
                        end
                    end
                    if (mem_wen) begin
                        checks++;
                        exp_w = (wr_q.size() != 0) ? wr_q.pop_front() : 24'hxxxxxx;
                        assert ({mem_addr, mem_wdata} === exp_w) else begin
                            errors++;
                            $error("FAIL write: observed addr/data %h expected %h",
                                   {mem_addr, mem_wdata}, exp_w);
                        end
                    end
                    if (mem_ren) begin
                        checks++;
                        exp_r = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
                        assert (mem_addr === exp_r) else begin
                            errors++;
                            $error("FAIL read: observed addr %h expected %h", mem_addr, exp_r);
                        end
                    end
                    if (done) done_cnt++;
                end
            end
        join_none

        #2;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic load: 0..63 at 0x0100.
        run_load(16'h0100, 0, 0, sum);
        chk("t1_model_sum", 32'(sum), 32'h07E0);
        wait_done("t1", 16'h07E0, 1'b0);

        // Readback corruption at 0x0105.
        corrupt = 1'b1;
        run_load(16'h0100, 0, 0, sum);
        wait_done("t2", 16'h07E0, 1'b1);
        corrupt = 1'b0;

        // Address wrap past 0xFFFF.
        run_load(16'hFFF0, 1, 0, sum);
        wait_done("t3", 16'h0040, 1'b0);

        // s_valid toggling every other cycle.
        run_load(16'h2000, 2, 1, sum);
        wait_done("t4", sum, 1'b0);
        prev_cs  = status_checksum;
        prev_err = status_error;

        // Abort after beat 10, with a beat offered in the abort cycle.
        d0 = done_cnt;
        do_start(16'h3000);
        for (int i = 0; i < 11; i++) send_beat(8'(i), 16'h3000 + 16'(i));
        s_valid = 1'b1;
        s_data  = 8'hAA;
        abort   = 1'b1;
        @(posedge clk); #1;
        abort   = 1'b0;
        s_valid = 1'b0;
        chk("t5_busy_fall", 32'(busy), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("t5_no_done", 32'(done_cnt), 32'(d0));
        chk("t5_cs_kept", 32'(status_checksum), 32'(prev_cs));
        chk("t5_err_kept", 32'(status_error), 32'(prev_err));
        chk("t5_writes_left", 32'(wr_q.size()), 32'd0);
        run_load(16'h0200, 0, 0, sum);
        wait_done("t5_reload", 16'h07E0, 1'b0);

        // Asynchronous reset mid-VERIFY.
        run_load(16'h0400, 0, 0, sum);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("t6_busy_verify", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        wr_q.delete();
        rd_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_load(16'h0500, 2, 0, sum);
        wait_done("t6_after", sum, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sl_preceptron_weight_loader.md
SL_PRECEPTRON_WEIGHT_LOADER -- requirements
Module: sl_preceptron_weight_loader

Interface
REQ-001 SHALL have parameter WEIGHTS_WIDTH, default 8, meaning bits per weight.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 16, meaning weight RAM address bits.
REQ-003 SHALL have parameter VECTOR_LENGTH, default 64, meaning weights per load.
REQ-004 SHALL have parameter CHECKSUM_WIDTH, default 16, meaning checksum accumulator bits.
REQ-005 One clock; reset is asynchronous and active-low: clk input 1, rising-edge clock; rst_n input 1, async active-low reset.
REQ-006 start  input  1  single-cycle load request.
REQ-007 abort  input  1  synchronous cancel of an active load.
REQ-008 base_addr  input  MEM_ADDR_WIDTH  first RAM address, sampled with start.
REQ-009 s_valid  input  1  weight stream beat valid.
REQ-010 s_data  input  WEIGHTS_WIDTH  weight stream beat.
REQ-011 s_ready  output  1  loader accepts a beat.
REQ-012 mem_wen / mem_ren  output  1 each  RAM write / read strobes.
REQ-013 mem_addr  output  MEM_ADDR_WIDTH  RAM address.
REQ-014 mem_wdata  output  WEIGHTS_WIDTH  RAM write data.
REQ-015 mem_rdata  input  WEIGHTS_WIDTH  RAM read data, valid the cycle after mem_ren.
REQ-016 busy  output  1  state is not IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 status_checksum  output  CHECKSUM_WIDTH  write-side checksum of last completed load.
REQ-019 status_error  output  1  readback checksum mismatch on last completed load.

Function
REQ-020 States SHALL be IDLE, LOAD, VERIFY, DRAIN, DONE.
REQ-021 IDLE: start=1 -> LOAD; latch base_addr; clear index, wr_sum, rd_sum; start while busy SHALL be ignored.
REQ-022 s_ready SHALL be 1 only in LOAD; a beat is accepted when s_valid && s_ready at a rising edge.
REQ-023 Accepted beat i (0-based) SHALL produce mem_wen=1, mem_addr=base+i, mem_wdata=s_data in the next cycle (registered, one-cycle latency); mem_wen=0 otherwise.
REQ-024 wr_sum SHALL add zero-extended s_data per accepted beat, modulo 2^CHECKSUM_WIDTH.
REQ-025 Acceptance of beat VECTOR_LENGTH-1 SHALL transition LOAD -> VERIFY and reset index to 0.
REQ-026 VERIFY SHALL issue one read per cycle: mem_ren=1, mem_addr=base+i, i=0..VECTOR_LENGTH-1, registered outputs; after the last read -> DRAIN.
REQ-027 rd_sum SHALL add zero-extended mem_rdata in the cycle after each mem_ren cycle; DRAIN lasts exactly one cycle to capture the final read.
REQ-028 DRAIN -> DONE; in DONE, done=1 for exactly one cycle, status_checksum<=wr_sum, status_error<=(wr_sum!=rd_sum); then -> IDLE.
REQ-029 Address arithmetic SHALL be modulo 2^MEM_ADDR_WIDTH (base near top wraps to 0).
REQ-030 mem_wen and mem_ren SHALL never both be 1 in one cycle.
REQ-031 Last write (cycle after final beat) and first read SHALL NOT overlap; first mem_ren occurs no earlier than the cycle after the last mem_wen.
REQ-032 abort=1 in LOAD/VERIFY/DRAIN SHALL -> IDLE next edge; no done; status_* unchanged; pending registered mem strobes deassert next cycle.
REQ-033 abort has priority over start and over beat acceptance in the same cycle.
REQ-034 s_valid gaps SHALL stall LOAD without side effects; VERIFY is not stallable.

Reset
REQ-035 rst_n=0 SHALL asynchronously force IDLE, s_ready=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0, busy=0, done=0, status_checksum=0, status_error=0, index and sums 0.
REQ-036 Reset mid-load SHALL discard the load; after release the block is IDLE and accepts start.

Verification
REQ-037 start, base=0x0100, 64 beats values 0..63 back-to-back, RAM model -> writes at 0x0100..0x013F, 64 reads, done once, status_checksum=0x07E0, status_error=0.
REQ-038 Same load with RAM model corrupting addr 0x0105 to 0xFF -> done, status_checksum=0x07E0, status_error=1.
REQ-039 base=0xFFF0, 64 beats of 0x01 -> writes at 0xFFF0..0xFFFF then 0x0000..0x002F, checksum 0x0040.
REQ-040 s_valid toggled every other cycle -> 64 writes, no duplicates/skips, mem_wen never coincides with mem_ren.
REQ-041 abort after beat 10 -> busy falls next cycle, no done, status_* retain prior values; new start loads cleanly.
REQ-042 rst_n asserted mid-VERIFY (asynchronous, between edges) -> all outputs 0 immediately; start after release completes normally.
